// File: rtl/game_flow_if.sv
// Game-flow signal bundle: frame/button/collision events in, game status out.
// Master is the game (drives events); slave is the flow controller.
interface game_flow_if #(
    parameter int LIVES_W = 2,
    parameter int SCORE_W = 8
);
    logic               frame_end;
    logic               start;
    logic               attack_released;
    logic               player_collision;
    logic               sword_collision;
    logic               sheep_collision;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic               attack_enable;
    logic               invulnerable;
    logic               game_rst_n;
    logic [1:0]         state;
    logic               hit_pulse;

    modport master (
        output frame_end, start, attack_released,
               player_collision, sword_collision, sheep_collision,
        input  lives, score, attack_enable, invulnerable, game_rst_n, state, hit_pulse
    );

    modport slave (
        input  frame_end, start, attack_released,
               player_collision, sword_collision, sheep_collision,
        output lives, score, attack_enable, invulnerable, game_rst_n, state, hit_pulse
    );
endinterface

// File: rtl/game_flow_controller.sv
// Game flow FSM (IDLE/PLAY/HURT/OVER) with lives, score, attack cooldown; all outputs
// registered, one cycle from input to output; no backpressure, every event is consumed.
module game_flow_controller #(
    parameter int MAX_LIVES       = 3,
    parameter int LIVES_W         = 2,
    parameter int SCORE_W         = 8,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int INVULN_FRAMES   = 60,
    parameter int GAMEOVER_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    game_flow_if.slave  bus
);
    localparam int FRAME_MAX = (INVULN_FRAMES > GAMEOVER_FRAMES) ? INVULN_FRAMES : GAMEOVER_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int COOL_W    = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HURT = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [LIVES_W-1:0] r_lives, w_lives_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [FRAME_W-1:0] r_frame, w_frame_nxt;
    logic [COOL_W-1:0]  r_cool, w_cool_nxt;
    logic               r_hit_pulse, w_hit_nxt;
    logic               r_attack_enable;
    logic               r_invulnerable;
    logic               r_game_rst_n;
    logic               r_sword_q, r_sheep_q;
    logic               w_score_clr;
    logic               w_active, w_active_nxt;
    logic               w_sword_rise, w_sheep_rise;

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_frame_nxt = r_frame;
        w_hit_nxt   = 1'b0;
        w_score_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = LIVES_W'(MAX_LIVES);
                    w_score_clr = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.frame_end && bus.player_collision) begin
                    w_hit_nxt   = 1'b1;
                    w_lives_nxt = r_lives - LIVES_W'(1);
                    if (r_lives > LIVES_W'(1)) begin
                        w_state_nxt = ST_HURT;
                        w_frame_nxt = FRAME_W'(INVULN_FRAMES);
                    end else begin
                        w_state_nxt = ST_OVER;
                        w_frame_nxt = FRAME_W'(GAMEOVER_FRAMES);
                    end
                end
            end
            ST_HURT, ST_OVER: begin
                // Leave on the frame that consumes the last counted frame.
                if (bus.frame_end) begin
                    w_frame_nxt = r_frame - FRAME_W'(1);
                    if (r_frame == FRAME_W'(1)) begin
                        w_state_nxt = (r_state == ST_HURT) ? ST_PLAY : ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cool_nxt = r_cool;
        if (bus.attack_released) begin
            w_cool_nxt = COOL_W'(COOLDOWN_FRAMES);
        end else if (bus.frame_end && (r_cool != '0)) begin
            w_cool_nxt = r_cool - COOL_W'(1);
        end
    end

    assign w_active     = (r_state == ST_PLAY) || (r_state == ST_HURT);
    assign w_active_nxt = (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_HURT);
    assign w_sword_rise = bus.sword_collision && !r_sword_q;
    assign w_sheep_rise = bus.sheep_collision && !r_sheep_q;

    always_comb begin
        w_score_nxt = r_score;
        if (w_score_clr) begin
            w_score_nxt = '0;
        end else if (w_active && w_sword_rise && !w_sheep_rise && (r_score != '1)) begin
            w_score_nxt = r_score + SCORE_W'(1);
        end else if (w_active && w_sheep_rise && !w_sword_rise && (r_score != '0)) begin
            w_score_nxt = r_score - SCORE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_lives         <= LIVES_W'(MAX_LIVES);
            r_score         <= '0;
            r_frame         <= '0;
            r_cool          <= '0;
            r_hit_pulse     <= 1'b0;
            r_attack_enable <= 1'b0;
            r_invulnerable  <= 1'b0;
            r_game_rst_n    <= 1'b0;
            r_sword_q       <= 1'b0;
            r_sheep_q       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_lives         <= w_lives_nxt;
            r_score         <= w_score_nxt;
            r_frame         <= w_frame_nxt;
            r_cool          <= w_cool_nxt;
            r_hit_pulse     <= w_hit_nxt;
            r_attack_enable <= (w_cool_nxt == '0) && w_active_nxt;
            r_invulnerable  <= (w_state_nxt == ST_HURT);
            r_game_rst_n    <= w_active_nxt;
            r_sword_q       <= bus.sword_collision;
            r_sheep_q       <= bus.sheep_collision;
        end
    end

    assign bus.state         = r_state;
    assign bus.lives         = r_lives;
    assign bus.score         = r_score;
    assign bus.hit_pulse     = r_hit_pulse;
    assign bus.attack_enable = r_attack_enable;
    assign bus.invulnerable  = r_invulnerable;
    assign bus.game_rst_n    = r_game_rst_n;
endmodule

// File: doc/game_flow_controller.md
GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 SHALL have parameter MAX_LIVES, default 3, meaning lives loaded at game start (1..2^LIVES_W-1).
REQ-002 SHALL have parameter LIVES_W, default 2, meaning width of the lives counter.
REQ-003 SHALL have parameter SCORE_W, default 8, meaning width of the score counter.
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 16, meaning frames the attack stays disabled after release (>=1).
REQ-005 SHALL have parameter INVULN_FRAMES, default 60, meaning frames of invulnerability after a hit (>=1).
REQ-006 SHALL have parameter GAMEOVER_FRAMES, default 120, meaning frames held in game-over before idle (>=1).
REQ-007 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-009 SHALL have port frame_end, input, 1, a one-cycle pulse once per video frame.
REQ-010 SHALL have port start, input, 1, a level-sensitive start button.
REQ-011 SHALL have port attack_released, input, 1, a one-cycle pulse when the attack button is released.
REQ-012 SHALL have port player_collision, input, 1, a level flag for a player/dragon overlap.
REQ-013 SHALL have port sword_collision, input, 1, a level flag for a sword/dragon overlap.
REQ-014 SHALL have port sheep_collision, input, 1, a level flag for a sheep/dragon overlap.
REQ-015 SHALL have port lives, output, LIVES_W, the remaining lives.
REQ-016 SHALL have port score, output, SCORE_W, the current score.
REQ-017 SHALL have port attack_enable, output, 1, asserted when the sword may hit.
REQ-018 SHALL have port invulnerable, output, 1, asserted while in HURT.
REQ-019 SHALL have port game_rst_n, output, 1, active-low reset to the gameplay entities.
REQ-020 SHALL have port state, output, 2, encoded as IDLE=00, PLAY=01, HURT=10, OVER=11.
REQ-021 SHALL have port hit_pulse, output, 1, a one-cycle sound trigger on life loss.

Function
REQ-022 SHALL register every output.
REQ-023 SHALL decrement one shared frame counter only in cycles where frame_end=1.
REQ-024 IDLE SHALL hold game_rst_n=0 and, when start=1, go to PLAY next cycle with lives=MAX_LIVES, score=0 and game_rst_n=1.
REQ-025 PLAY SHALL sample player_collision only in a frame_end cycle; a hit then SHALL decrement lives and assert hit_pulse for exactly one cycle.
REQ-026 On a PLAY hit with lives>1, the block SHALL go to HURT and load the frame counter with INVULN_FRAMES.
REQ-027 On a PLAY hit with lives==1, the block SHALL go to OVER with lives=0, game_rst_n=0 and the frame counter loaded with GAMEOVER_FRAMES.
REQ-028 HURT SHALL ignore player_collision and return to PLAY on the frame_end at which the counter is 1 (exactly INVULN_FRAMES frame_end pulses spent in HURT).
REQ-029 OVER SHALL ignore start and all collisions and go to IDLE after GAMEOVER_FRAMES frame_end pulses.
REQ-030 attack_released SHALL load the cooldown counter with COOLDOWN_FRAMES, and the cooldown counter SHALL decrement on frame_end down to a floor of 0.
REQ-031 When attack_released and frame_end coincide, the reload SHALL win.
REQ-032 attack_enable SHALL equal (cooldown==0) AND (state is PLAY or HURT), registered.
REQ-033 A rising edge of sword_collision in PLAY or HURT SHALL increment score, saturating at 2^SCORE_W-1.
REQ-034 A rising edge of sheep_collision in PLAY or HURT SHALL decrement score, saturating at 0.
REQ-035 When both rising edges occur in the same cycle, score SHALL be left unchanged.
REQ-036 The edge-detect history registers SHALL update in every state, so that a level already high on entry to PLAY does not count as an edge.

Reset
REQ-037 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, lives=MAX_LIVES, score=0, attack_enable=0, invulnerable=0, game_rst_n=0, hit_pulse=0, both counters=0 and the edge history=0.
REQ-038 Reset SHALL override every other input in that cycle, including mid-HURT and mid-OVER.
REQ-039 Outputs SHALL take effect from the first edge after rst_n returns to 1.

Verification
REQ-040 SHALL cover: reset, then start=1 for 1 cycle -> next cycle state=01, lives=3, game_rst_n=1, score=0.
REQ-041 SHALL cover, with INVULN_FRAMES=3: player_collision high across a frame_end in PLAY -> lives 3->2, hit_pulse for 1 cycle, state=10, invulnerable=1; collisions ignored; state=01 after the 3rd frame_end.
REQ-042 SHALL cover, with GAMEOVER_FRAMES=2: three separate hits -> lives=0, state=11, game_rst_n=0; start ignored; state=00 after 2 frame_ends.
REQ-043 SHALL cover, with COOLDOWN_FRAMES=4: attack_released in PLAY -> attack_enable=0 for 4 frame_ends, then 1; attack_released coinciding with a frame_end reloads the counter to 4.
REQ-044 SHALL cover, with SCORE_W=2: 5 sword_collision rising edges -> score 3 (saturated); then 4 sheep_collision edges -> score 0; a simultaneous rise of both -> score unchanged.
REQ-045 SHALL cover: rst_n=0 asserted mid-HURT -> next cycle all outputs at their REQ-037 reset values.
